// File: rtl/nes_cpu_pkg.sv
// Shared CPU definitions: address width, boot vector, fetch-stage instruction record
// and the 6502 opcode length decoder.
package nes_cpu_pkg;

  localparam int unsigned MEM_ADDR_SIZE = 16;

  typedef logic [MEM_ADDR_SIZE-1:0] addr_t;

  localparam addr_t BOOT_ADDR = 16'hFFFC;

  // One assembled instruction as handed to decode.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    addr_t       pc;
  } fetch_instr_t;

  // Total instruction length in bytes (1..3) from the opcode alone. Illegal opcodes
  // get whatever this rule yields; there is no trap.
  function automatic logic [1:0] instr_len(input logic [7:0] op);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = op[3:0];
    hi = op[7:4];
    if (lo >= 4'hC || (lo == 4'h9 && hi[0]) || op == 8'h20) begin
      return 2'd3;
    end
    if (lo == 4'h8 || lo == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch byte buffer: one push per cycle, pop of 1..3 bytes, synchronous
// clear. Exposes the three bytes at the head plus the current fill count.
module fetch_queue #(
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [7:0]                   push_data_i,
  input  logic                         pop_i,
  input  logic [1:0]                   pop_len_i,
  output logic [7:0]                   head0_o,
  output logic [7:0]                   head1_o,
  output logic [7:0]                   head2_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] ptr,
                                               input int unsigned inc);
    int unsigned sum;
    sum = 32'(ptr) + inc;
    if (sum >= Depth) begin
      sum = sum - Depth;
    end
    return PtrW'(sum);
  endfunction

  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[ptr_add(rd_ptr_q, 1)];
  assign head2_o = mem_q[ptr_add(rd_ptr_q, 2)];
  assign count_o = count_q;

  // Next pointers and count; clear wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = ptr_add(wr_ptr_q, 1);
      end
      if (pop_i) begin
        rd_ptr_d = ptr_add(rd_ptr_q, 32'(pop_len_i));
      end
      count_d = count_q + CntW'(push_i) - (pop_i ? CntW'(pop_len_i) : '0);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage; zeroed on reset so the idle head decodes as opcode 0x00.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one byte read per cycle into the prefetch queue and
// presents whole 6502 instructions to decode over a valid/ready handshake.
module fetch_unit
  import nes_cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [MEM_ADDR_SIZE-1:0] flush_pc_i,
  output logic                     mem_req_o,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
  input  logic                     mem_rvalid_i,
  input  logic [7:0]               mem_rdata_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [7:0]               instr_opcode_o,
  output logic [15:0]              instr_operand_o,
  output logic [1:0]               instr_len_o,
  output logic [MEM_ADDR_SIZE-1:0] instr_pc_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 3) begin : gen_depth_check
    $error("fetch_unit: FIFO_DEPTH must be at least 3");
  end

  addr_t           fetch_pc_q, fetch_pc_d;
  addr_t           head_pc_q, head_pc_d;
  logic            req_q, req_d;
  logic [7:0]      head0, head1, head2;
  logic [CntW-1:0] count;
  logic [1:0]      head_len;
  logic            push;
  logic            pop;
  fetch_instr_t    instr;

  // Reserve a slot for the byte still in flight so the queue can never overflow.
  assign mem_req_o  = !rst_i && !flush_i && ((32'(count) + 32'(req_q)) < FIFO_DEPTH);
  assign mem_addr_o = fetch_pc_q;

  assign push     = mem_rvalid_i && !flush_i;
  assign head_len = instr_len(head0);

  assign instr_valid_o = !flush_i && (count >= CntW'(head_len));
  assign pop           = instr_valid_o && instr_ready_i;

  fetch_queue #(
    .Depth (FIFO_DEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .push_i      (push),
    .push_data_i (mem_rdata_i),
    .pop_i       (pop),
    .pop_len_i   (head_len),
    .head0_o     (head0),
    .head1_o     (head1),
    .head2_o     (head2),
    .count_o     (count)
  );

  // Assemble the head instruction; operand bytes beyond its length read as zero.
  always_comb begin
    instr.opcode  = head0;
    instr.len     = head_len;
    instr.operand = 16'h0000;
    if (head_len != 2'd1) begin
      instr.operand[7:0] = head1;
    end
    if (head_len == 2'd3) begin
      instr.operand[15:8] = head2;
    end
    instr.pc = head_pc_q;
  end

  assign instr_opcode_o  = instr.opcode;
  assign instr_operand_o = instr.operand;
  assign instr_len_o     = instr.len;
  assign instr_pc_o      = instr.pc;

  // Next fetch/head addresses; a flush redirects both and cancels the pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    req_d      = mem_req_o;
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
      head_pc_d  = flush_pc_i;
      req_d      = 1'b0;
    end else begin
      if (mem_req_o) begin
        fetch_pc_d = fetch_pc_q + addr_t'(1);
      end
      if (pop) begin
        head_pc_d = head_pc_q + addr_t'(head_len);
      end
    end
  end

  // Address and outstanding-request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= BOOT_ADDR;
      head_pc_q  <= BOOT_ADDR;
      req_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      req_q      <= req_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte-addressed memory model with one-cycle read
// latency, scoreboard of expected instructions fed from a reference byte stream.
module tb_fetch_unit;
  import nes_cpu_pkg::*;

  localparam int Depth = 4;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] operand;
    logic [1:0]  len;
    addr_t       pc;
  } exp_t;

  typedef struct packed {
    logic [7:0] op;
    logic [1:0] len;
  } spot_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  addr_t       flush_pc_i = '0;
  logic        mem_req_o;
  addr_t       mem_addr_o;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [7:0]  instr_opcode_o;
  logic [15:0] instr_operand_o;
  logic [1:0]  instr_len_o;
  addr_t       instr_pc_o;

  logic [7:0] mem [65536];

  int    n_vec = 0;
  int    n_miss = 0;
  exp_t  sb_q[$];
  addr_t sb_pc;
  logic  mon_en = 1'b0;
  int    tb_cnt;
  logic  tb_req;
  addr_t tb_fpc;
  exp_t  mon_e;
  logic  mon_req;
  logic  mon_valid;
  int    mon_pop;

  exp_t  boot_vec [3];
  spot_t spot_vec [8];

  fetch_unit #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_opcode_o  (instr_opcode_o),
    .instr_operand_o (instr_operand_o),
    .instr_len_o     (instr_len_o),
    .instr_pc_o      (instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory answers every request exactly one cycle later.
  always @(posedge clk_i) begin
    mem_rvalid_i <= mem_req_o;
    mem_rdata_i  <= mem[mem_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent length table, organised by low nibble.
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    case (op[3:0])
      4'hC, 4'hD, 4'hE, 4'hF: ref_len = 2'd3;
      4'h9:                   ref_len = op[4] ? 2'd3 : 2'd2;
      4'h8, 4'hA:             ref_len = 2'd1;
      4'h0: begin
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) ref_len = 2'd1;
        else if (op == 8'h20)                          ref_len = 2'd3;
        else                                           ref_len = 2'd2;
      end
      default:                ref_len = 2'd2;
    endcase
  endfunction

  function automatic exp_t model_at(input addr_t pc);
    exp_t  e;
    addr_t p1;
    addr_t p2;
    p1        = pc + 16'd1;
    p2        = pc + 16'd2;
    e.op      = mem[pc];
    e.len     = ref_len(e.op);
    e.pc      = pc;
    e.operand = 16'h0000;
    if (e.len >= 2'd2) e.operand[7:0] = mem[p1];
    if (e.len == 2'd3) e.operand[15:8] = mem[p2];
    return e;
  endfunction

  function automatic void sb_refill();
    exp_t e;
    while (sb_q.size() < 8) begin
      e = model_at(sb_pc);
      sb_q.push_back(e);
      sb_pc = sb_pc + addr_t'(e.len);
    end
  endfunction

  function automatic void sb_reset(input addr_t pc);
    sb_q.delete();
    sb_pc = pc;
    sb_refill();
  endfunction

  // Mid-cycle monitor: request rule, valid rule, handshake contents, then advance model.
  always @(negedge clk_i) begin
    if (mon_en) begin
      mon_req = !flush_i && ((tb_cnt + int'(tb_req)) < Depth);
      chk("mem_req", 32'(mem_req_o), 32'(mon_req));
      if (mon_req) chk("mem_addr", 32'(mem_addr_o), 32'(tb_fpc));
      mon_valid = !flush_i && (sb_q.size() > 0) && (tb_cnt >= int'(sb_q[0].len));
      chk("instr_valid", 32'(instr_valid_o), 32'(mon_valid));
      mon_pop = 0;
      if (instr_valid_o && instr_ready_i) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL sb_underflow: handshake at pc %0h, required an expected entry",
                   instr_pc_o);
        end else begin
          mon_e = sb_q.pop_front();
          chk("opcode", 32'(instr_opcode_o), 32'(mon_e.op));
          chk("operand", 32'(instr_operand_o), 32'(mon_e.operand));
          chk("len", 32'(instr_len_o), 32'(mon_e.len));
          chk("pc", 32'(instr_pc_o), 32'(mon_e.pc));
          mon_pop = int'(mon_e.len);
          sb_refill();
        end
      end
      if (flush_i) begin
        tb_cnt = 0;
        tb_req = 1'b0;
        tb_fpc = flush_pc_i;
      end else begin
        tb_cnt = tb_cnt + (mem_rvalid_i ? 1 : 0) - mon_pop;
        tb_req = mon_req;
        if (mon_req) tb_fpc = tb_fpc + 16'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Flush held for one cycle; returns one step into cycle t+1.
  task automatic do_flush(input addr_t pc);
    step();
    flush_i    = 1'b1;
    flush_pc_i = pc;
    sb_reset(pc);
    step();
    flush_i = 1'b0;
  endtask

  initial begin
    logic found;
    addr_t rpc;

    boot_vec[0] = '{op: 8'hEA, operand: 16'h0000, len: 2'd1, pc: 16'hFFFC};
    boot_vec[1] = '{op: 8'hA9, operand: 16'h0005, len: 2'd2, pc: 16'hFFFD};
    boot_vec[2] = '{op: 8'h4C, operand: 16'h8000, len: 2'd3, pc: 16'hFFFF};
    spot_vec[0] = '{op: 8'h20, len: 2'd3};
    spot_vec[1] = '{op: 8'h19, len: 2'd3};
    spot_vec[2] = '{op: 8'h09, len: 2'd2};
    spot_vec[3] = '{op: 8'hA2, len: 2'd2};
    spot_vec[4] = '{op: 8'h0A, len: 2'd1};
    spot_vec[5] = '{op: 8'h60, len: 2'd1};
    spot_vec[6] = '{op: 8'h00, len: 2'd1};
    spot_vec[7] = '{op: 8'h4C, len: 2'd3};

    for (int i = 0; i < 65536; i++) mem[16'(i)] = 8'($urandom);
    mem[16'hFFFC] = 8'hEA;
    mem[16'hFFFD] = 8'hA9;
    mem[16'hFFFE] = 8'h05;
    mem[16'hFFFF] = 8'h4C;
    mem[16'h0000] = 8'h00;
    mem[16'h0001] = 8'h80;
    mem[16'h1234] = 8'hEA;
    mem[16'h3000] = 8'h4C;
    mem[16'h3001] = 8'h34;
    mem[16'h3002] = 8'h12;
    for (int i = 0; i < 256; i++) mem[16'h4000 + 16'(i)] = 8'(i);

    // Reset values.
    instr_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'(BOOT_ADDR));
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_opcode", 32'(instr_opcode_o), 32'd0);
    chk("rst_operand", 32'(instr_operand_o), 32'd0);
    chk("rst_len", 32'(instr_len_o), 32'd1);
    chk("rst_pc", 32'(instr_pc_o), 32'(BOOT_ADDR));

    // Boot sequence from the table, continuing through the 0xFFFF wrap.
    step();
    rst_i  = 1'b0;
    tb_cnt = 0;
    tb_req = 1'b0;
    tb_fpc = BOOT_ADDR;
    sb_q.delete();
    for (int i = 0; i < 3; i++) sb_q.push_back(boot_vec[i]);
    sb_pc = 16'h0002;
    sb_refill();
    mon_en = 1'b1;
    @(negedge clk_i);
    chk("c0_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);
    chk("c1_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);
    chk("c2_valid", 32'(instr_valid_o), 32'd1);
    repeat (20) step();

    // Backpressure: queue saturates, requests stop, stream resumes intact.
    instr_ready_i = 1'b0;
    repeat (20) step();
    @(negedge clk_i);
    chk("bp_req", 32'(mem_req_o), 32'd0);
    chk("bp_valid", 32'(instr_valid_o), 32'd1);
    step();
    instr_ready_i = 1'b1;
    repeat (30) step();

    // Flush coinciding with a would-be pop and an arriving byte.
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      step();
      if (instr_valid_o && mem_rvalid_i) found = 1'b1;
    end
    chk("flush_window_found", 32'(found), 32'd1);
    flush_i    = 1'b1;
    flush_pc_i = 16'h1234;
    sb_reset(16'h1234);
    @(negedge clk_i);
    chk("flush_valid", 32'(instr_valid_o), 32'd0);
    chk("flush_req", 32'(mem_req_o), 32'd0);
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_t1_req", 32'(mem_req_o), 32'd1);
    chk("flush_t1_addr", 32'(mem_addr_o), 32'h1234);
    @(negedge clk_i);
    chk("flush_t2_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);
    chk("flush_t3_valid", 32'(instr_valid_o), 32'd1);
    chk("flush_t3_pc", 32'(instr_pc_o), 32'h1234);

    // 3-byte instruction first valid four cycles after the redirect request.
    do_flush(16'h3000);
    repeat (3) @(negedge clk_i);
    @(negedge clk_i);
    chk("len3_t4_valid", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);
    chk("len3_t5_valid", 32'(instr_valid_o), 32'd1);
    chk("len3_operand", 32'(instr_operand_o), 32'h1234);

    // Length sweep over all opcodes, then the spot table.
    instr_ready_i = 1'b0;
    for (int op = 0; op < 256; op++) begin
      do_flush(16'h4000 + 16'(op));
      repeat (3) @(negedge clk_i);
      chk("len_sweep", 32'(instr_len_o), 32'(ref_len(8'(op))));
    end
    for (int i = 0; i < 8; i++) begin
      do_flush(16'h4000 + 16'(spot_vec[i].op));
      repeat (3) @(negedge clk_i);
      chk("len_spot", 32'(instr_len_o), 32'(spot_vec[i].len));
    end

    // Random ready/flush stress.
    for (int c = 0; c < 3000; c++) begin
      step();
      instr_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        rpc        = 16'($urandom);
        flush_i    = 1'b1;
        flush_pc_i = rpc;
        sb_reset(rpc);
      end else begin
        flush_i = 1'b0;
      end
    end
    step();
    flush_i       = 1'b0;
    instr_ready_i = 1'b1;
    repeat (20) step();
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
